// File: rtl/aes_128_out_packer.sv
// Output packer behind aes_128_top: buffers 128-bit blocks in a FIFO and
// serializes each into four 32-bit words on a valid/ready stream.
module aes_128_out_packer #(
  parameter int DEPTH     = 8,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       kill_n,
  input  logic                       flush,
  input  logic                       in_en,
  input  logic [127:0]               in_data,
  input  logic                       m_ready,
  output logic                       m_valid,
  output logic [31:0]                m_data,
  output logic                       m_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       idle,
  output logic                       ovf_irq_pulse,
  output logic [7:0]                 ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t          state, state_d;
  logic [127:0]    mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   level_q;
  logic [127:0]    blk;
  logic [1:0]      idx, idx_d;
  logic            hs, pop, push, drop, full, nonempty;

  assign full     = (level_q == LW'(DEPTH));
  assign nonempty = (level_q != '0);
  assign hs       = (state == SEND) & m_ready;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    pop     = 1'b0;
    case (state)
      EMPTY: if (nonempty) begin
        pop     = 1'b1;
        state_d = SEND;
        idx_d   = 2'd0;
      end
      SEND: if (hs) begin
        idx_d = idx + 2'd1;
        // last word: chain straight into the next block to avoid a bubble
        if (idx == 2'd3) begin
          if (nonempty) pop = 1'b1;
          else          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = EMPTY;
      idx_d   = 2'd0;
    end
  end

  // a full FIFO still accepts a block if the head leaves on the same edge
  assign push = in_en & ~flush & (~full | pop);
  assign drop = in_en & ~flush & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state         <= EMPTY;
      idx           <= 2'd0;
      wptr          <= '0;
      rptr          <= '0;
      level_q       <= '0;
      blk           <= '0;
      ovf_irq_pulse <= 1'b0;
      ovf_cnt       <= 8'd0;
    end else if (flush) begin
      state         <= EMPTY;
      idx           <= 2'd0;
      wptr          <= '0;
      rptr          <= '0;
      level_q       <= '0;
      blk           <= '0;
      ovf_irq_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level_q       <= level_q + LW'(push) - LW'(pop);
      if (pop)
        blk <= mem[rptr];
      else if (hs)
        blk <= MSW_FIRST ? {blk[95:0], 32'd0} : {32'd0, blk[127:32]};
      ovf_irq_pulse <= drop;
      if (drop && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // blk shifts in zeros, so m_data reads 0 whenever nothing is being sent
  assign m_data  = MSW_FIRST ? blk[127:96] : blk[31:0];
  assign m_valid = (state == SEND);
  assign m_last  = (state == SEND) & (idx == 2'd3);
  assign level   = level_q;
  assign idle    = ~nonempty & (state == EMPTY);

endmodule

// File: tb/tb_aes_128_out_packer.sv
// Directed bench for aes_128_out_packer with a word scoreboard checked on
// every output handshake.
module tb_aes_128_out_packer;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         kill_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_en = 1'b0;
  logic [127:0] in_data = '0;
  logic         m_ready = 1'b0;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_last;
  logic [3:0]   level;
  logic         idle;
  logic         ovf_irq_pulse;
  logic [7:0]   ovf_cnt;

  aes_128_out_packer #(.DEPTH(DEPTH), .MSW_FIRST(1'b0)) dut (
    .clk(clk), .kill_n(kill_n), .flush(flush), .in_en(in_en),
    .in_data(in_data), .m_ready(m_ready), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .level(level), .idle(idle),
    .ovf_irq_pulse(ovf_irq_pulse), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  logic [32:0] expq[$];
  int          hs_cnt = 0;
  logic [31:0] held = '0;
  logic        held_v = 1'b0;
  int          peak, vcyc, runs, pulses;
  logic        prev_v;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes happen at the posedge; inputs/outputs are stable at the negedge before it.
  always @(negedge clk) begin
    logic [32:0] e;
    if (kill_n) begin
      if (m_valid && held_v) chk("hold_stable", m_data, held);
      held_v = m_valid && !m_ready;
      held   = m_data;
      if (m_valid && m_ready) begin
        hs_cnt++;
        chk("queue_nonempty", (expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("word", {m_last, m_data}, e);
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic clr_stats();
    peak = 0; vcyc = 0; runs = 0; pulses = 0; prev_v = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(level) > peak) peak = int'(level);
    if (m_valid) vcyc++;
    if (prev_v && !m_valid) runs++;
    if (ovf_irq_pulse) pulses++;
    prev_v = m_valid;
  endtask

  task automatic push_blk(input logic [127:0] d, input bit acc);
    in_en   = 1'b1;
    in_data = d;
    if (acc)
      for (int i = 0; i < 4; i++) expq.push_back({(i == 3) ? 1'b1 : 1'b0, d[32*i +: 32]});
    tick();
    in_en = 1'b0;
  endtask

  task automatic drain(input int max);
    bit done = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < max; c++) begin
      if (idle && expq.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_done", done, 1);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    bit done;
    logic [127:0] tv;

    // reset values
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_level", level, 0);
    chk("rst_idle", idle, 1);
    chk("rst_irq", ovf_irq_pulse, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    @(negedge clk);
    kill_n = 1'b1;
    tick();

    // single block, two-clock latency
    m_ready = 1'b1;
    tv = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    push_blk(tv, 1'b1);
    chk("lat_valid_k", m_valid, 0);
    chk("lat_idle_k", idle, 0);
    tick();
    chk("lat_valid_k1", m_valid, 1);
    chk("lat_first_word", m_data, 32'h70b4c55a);
    drain(20);
    chk("single_idle", idle, 1);

    // backpressure: m_ready 1,0,0,1,...
    hs0 = hs_cnt;
    m_ready = 1'b0;
    push_blk(tv, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 3 == 0);
      tick();
      if (idle && expq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("bp_done", done, 1);
    chk("bp_handshakes", hs_cnt - hs0, 4);

    // burst of three blocks, no bubbles
    m_ready = 1'b1;
    clr_stats();
    hs0 = hs_cnt;
    for (int b = 0; b < 3; b++) push_blk(rnd_blk(), 1'b1);
    drain(40);
    chk("burst_peak_level", peak, 2);
    chk("burst_valid_cycles", vcyc, 12);
    chk("burst_valid_runs", runs, 1);
    chk("burst_handshakes", hs_cnt - hs0, 12);

    // overflow: 10 blocks with the output stalled
    m_ready = 1'b0;
    clr_stats();
    for (int b = 0; b < 10; b++) push_blk(rnd_blk(), b < 9);
    chk("ovf_pulse", ovf_irq_pulse, 1);
    chk("ovf_cnt_1", ovf_cnt, 1);
    chk("ovf_level", level, DEPTH);
    tick();
    chk("ovf_pulse_clear", ovf_irq_pulse, 0);
    chk("ovf_pulse_count", pulses, 1);

    // full FIFO, push on the same edge as the last-word pop
    m_ready = 1'b1;
    tick(); tick(); tick();
    chk("full_m_last", m_last, 1);
    chk("full_level_pre", level, DEPTH);
    push_blk(rnd_blk(), 1'b1);
    chk("full_level_post", level, DEPTH);
    chk("full_no_pulse", ovf_irq_pulse, 0);
    chk("full_ovf_cnt", ovf_cnt, 1);
    drain(200);

    // flush mid-block with level 3
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) push_blk(rnd_blk(), 1'b1);
    chk("fl_level_pre", level, 3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush = 1'b1;
    in_en = 1'b1;
    in_data = rnd_blk();
    tick();
    flush = 1'b0;
    in_en = 1'b0;
    expq.delete();
    chk("fl_m_valid", m_valid, 0);
    chk("fl_level", level, 0);
    chk("fl_idle", idle, 1);
    chk("fl_ovf_cnt", ovf_cnt, 1);
    chk("fl_irq", ovf_irq_pulse, 0);
    chk("fl_m_data", m_data, 0);
    tick(); tick(); tick();
    chk("fl_idle_hold", idle, 1);
    chk("fl_valid_hold", m_valid, 0);

    // saturate the drop counter
    for (int b = 0; b < 270; b++) push_blk(rnd_blk(), b < 9);
    chk("sat_ovf_cnt", ovf_cnt, 8'hff);
    chk("sat_level", level, DEPTH);

    // asynchronous kill mid-transfer
    m_ready = 1'b1;
    tick(); tick();
    chk("kill_pre_valid", m_valid, 1);
    #1 kill_n = 1'b0;
    #1;
    expq.delete();
    chk("kill_m_valid", m_valid, 0);
    chk("kill_m_data", m_data, 0);
    chk("kill_m_last", m_last, 0);
    chk("kill_level", level, 0);
    chk("kill_idle", idle, 1);
    chk("kill_irq", ovf_irq_pulse, 0);
    chk("kill_ovf_cnt", ovf_cnt, 0);
    #1 kill_n = 1'b1;
    tick();
    chk("post_kill_idle", idle, 1);
    chk("post_kill_valid", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
